fir_filter_param: RTL

- Parametrised, reprogrammable pipelined FIR filter; successor to the fixed 9-tap low-pass FIR.
- Generic tap count and data/coefficient widths; valid-qualified sample stream.
- Double-buffered coefficient bank, loadable at run time with glitch-free commit.
- Sits between the ADC sample front-end and downstream decimation/DSP; runs on the 100 MHz sample clock.

---
 rtl/fir_filter_param.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fir_filter_param.sv
// Reprogrammable pipelined FIR with double-buffered coefficients; optional output saturation via FIR_PARAM_SAT_EN.
// Latency: 2+ceil(log2(TAPS)) edges from IN_VALID capture to OUT_VALID (6 at TAPS=9).
// Backpressure: none; one OUT_VALID per accepted IN_VALID, OUT_DATA holds between valids.
module fir_filter_param #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 9,
    parameter int FRAC_BITS = 14,
    parameter int ADDR_W    = 6
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     IN_VALID,
    input  logic signed [DATA_W-1:0] IN_DATA,
    input  logic                     COEF_WE,
    input  logic [ADDR_W-1:0]        COEF_ADDR,
    input  logic signed [COEF_W-1:0] COEF_DATA,
    input  logic                     COEF_COMMIT,
    output logic                     OUT_VALID,
    output logic signed [DATA_W-1:0] OUT_DATA,
    output logic                     OVF
);

    localparam int S      = $clog2(TAPS);
    localparam int L      = 2 + S;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + S;

    // Operand count at tree level lvl (level 0 = products).
    function automatic int nodes(input int lvl);
        int n;
        n = TAPS;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int clamp_idx(input int x);
        return (x < TAPS) ? x : TAPS - 1;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [COEF_W-1:0] b);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return ACC_W'(p);
    endfunction

    logic signed [DATA_W-1:0] tap    [TAPS];
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];
    logic signed [ACC_W-1:0]  lvl    [S][TAPS];
    logic [L-2:0]             vpipe;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] out_next;

    // Non-blocking copy means a same-edge write lands in shadow only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (COEF_WE && int'(COEF_ADDR) == k) shadow[k] <= COEF_DATA;
                if (COEF_COMMIT) active[k] <= shadow[k];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
        end else if (IN_VALID) begin
            tap[0] <= IN_DATA;
            for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
        end
    end

    // Products and all but the last tree level; the last level feeds the output register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s < S; s++)
                for (int i = 0; i < TAPS; i++) lvl[s][i] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) lvl[0][k] <= mul(tap[k], active[k]);
            for (int s = 1; s < S; s++) begin
                for (int i = 0; i < TAPS; i++) begin
                    if (i < nodes(s)) begin
                        if (2*i + 1 < nodes(s-1))
                            lvl[s][i] <= lvl[s-1][clamp_idx(2*i)] + lvl[s-1][clamp_idx(2*i+1)];
                        else
                            lvl[s][i] <= lvl[s-1][clamp_idx(2*i)];
                    end else begin
                        lvl[s][i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        acc = lvl[S-1][0] + lvl[S-1][1];
    end

    logic unused_acc;
    assign unused_acc = ^acc;

`ifdef FIR_PARAM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] hi;
    logic                    clamp;

    always_comb begin
        hi       = acc >>> FRAC_BITS;
        clamp    = 1'b0;
        out_next = hi[DATA_W-1:0];
        if (hi > SAT_HI) begin
            out_next = SAT_HI[DATA_W-1:0];
            clamp    = 1'b1;
        end else if (hi < SAT_LO) begin
            out_next = SAT_LO[DATA_W-1:0];
            clamp    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) OVF <= 1'b0;
        else if (vpipe[L-2] && clamp) OVF <= 1'b1;
    end
`else
    always_comb begin
        out_next = acc[FRAC_BITS +: DATA_W];
    end

    assign OVF = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vpipe     <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else begin
            vpipe     <= {vpipe[L-3:0], IN_VALID};
            OUT_VALID <= vpipe[L-2];
            if (vpipe[L-2]) OUT_DATA <= out_next;
        end
    end

endmodule
